switch_debounce: RTL and testbench

//   Upstream input-conditioning stage for the two-input gate block. Takes two raw,

---
 rtl/debounce_pkg.sv | 9 +
 rtl/debounce_channel.sv | 83 ++++++++
 rtl/switch_debounce.sv | 64 ++++++
 tb/tb_switch_debounce.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and parameter floors for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW} db_state_t;

  localparam int SYNC_STAGES_MIN     = 2;
  localparam int DEBOUNCE_CYCLES_MIN = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: synchronizer chain feeding a 4-state debounce FSM.
// out_next is exported so the top can register change/edge pulses in step with out.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic out_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  db_state_t              state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;

  // Pure flop chain: nothing between stages so metastability settles cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], raw};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOW;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      out   <= out_next;
    end
  end

  // Counter is zero outside the WAIT states, so every WAIT entry starts from 0.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    out_next   = out;
    unique case (state)
      S_LOW: begin
        if (s) state_next = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (!s) begin
          state_next = S_LOW;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HIGH;
          out_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!s) state_next = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (s) begin
          state_next = S_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next = S_LOW;
          out_next   = 1'b0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_LOW;
        out_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/switch_debounce.sv
// Two-switch debouncer feeding the gate block's a/b inputs, plus a change strobe.
// Optional per-edge pulses a_rise/a_fall/b_rise/b_fall under SWITCH_DEBOUNCE_EDGE_EN.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a_raw,
  input  logic sw_b_raw,
  output logic a,
  output logic b,
  output logic changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
`endif
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("switch_debounce: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_CYCLES_MIN) begin : g_bad_deb
    $error("switch_debounce: DEBOUNCE_CYCLES must be >= %0d", DEBOUNCE_CYCLES_MIN);
  end

  logic a_next, b_next;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch_a (
    .clk(clk), .rst_n(rst_n), .raw(sw_a_raw), .out(a), .out_next(a_next)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .raw(sw_b_raw), .out(b), .out_next(b_next)
  );

  // Registered from next-vs-current so the pulse lands in the cycle a/b change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= (a_next != a) | (b_next != b);
  end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rise <= 1'b0;
      a_fall <= 1'b0;
      b_rise <= 1'b0;
      b_fall <= 1'b0;
    end else begin
      a_rise <= a_next & ~a;
      a_fall <= ~a_next & a;
      b_rise <= b_next & ~b;
      b_fall <= ~b_next & b;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: vector table, directed corner sequences and random
// stimulus, all checked against a window-based reference model.
module tb_switch_debounce;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n, sw_a_raw, sw_b_raw;
  logic a, b, changed;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic a_rise, a_fall, b_rise, b_fall;
`endif

  switch_debounce #(.DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_a_raw(sw_a_raw), .sw_b_raw(sw_b_raw),
    .a(a), .b(b), .changed(changed)
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    , .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: raw samples per edge; an output flips at an edge once the synchronized
  // level seen over the last DEB+1 edges all differs from the current output.
  bit hist [2][$];
  bit seen [2][$];
  bit mout [2];
  bit mrise[2];
  bit mfall[2];
  bit mchg;

  typedef struct {
    bit ra;
    bit rb;
    int hold;
    bit ea;
    bit eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      hist[ch].delete();
      seen[ch].delete();
      mout[ch]  = 1'b0;
      mrise[ch] = 1'b0;
      mfall[ch] = 1'b0;
    end
    mchg = 1'b0;
  endtask

  task automatic model_edge(input bit ra, input bit rb);
    bit raws[2];
    raws[0] = ra;
    raws[1] = rb;
    mchg = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      bit s_seen;
      bit flip;
      s_seen = (hist[ch].size() >= SYNC) ? hist[ch][hist[ch].size() - SYNC] : 1'b0;
      hist[ch].push_back(raws[ch]);
      if (hist[ch].size() > SYNC) void'(hist[ch].pop_front());
      seen[ch].push_back(s_seen);
      if (seen[ch].size() > DEB + 1) void'(seen[ch].pop_front());
      flip = (seen[ch].size() == DEB + 1);
      foreach (seen[ch][i]) if (seen[ch][i] == mout[ch]) flip = 1'b0;
      mrise[ch] = flip & ~mout[ch];
      mfall[ch] = flip & mout[ch];
      if (flip) mout[ch] = ~mout[ch];
      mchg |= flip;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(sw_a_raw, sw_b_raw);
    #1;
    chk("cyc_a", a, mout[0]);
    chk("cyc_b", b, mout[1]);
    chk("cyc_changed", changed, mchg);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    chk("cyc_a_rise", a_rise, mrise[0]);
    chk("cyc_a_fall", a_fall, mfall[0]);
    chk("cyc_b_rise", b_rise, mrise[1]);
    chk("cyc_b_fall", b_fall, mfall[1]);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t vecs[$];
  int   pulses;

  initial begin
    rst_n = 1'b0; sw_a_raw = 1'b0; sw_b_raw = 1'b0;
    model_reset();
    #12;
    chk("init_a", a, 0);
    chk("init_b", b, 0);
    chk("init_changed", changed, 0);
    rst_n = 1'b1;
    steps(3);

    // 1. Async reset mid-cycle with both switches held high
    sw_a_raw = 1'b1; sw_b_raw = 1'b1;
    steps(10);
    chk("pre_rst_a", a, 1);
    chk("pre_rst_b", b, 1);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_changed", changed, 0);
    #3 rst_n = 1'b1;
    // First edge after release is the first sampling edge; a rises 6 edges later.
    steps(6);
    chk("rst_rel_a_early", a, 0);
    step();
    chk("rst_rel_a", a, 1);
    chk("rst_rel_changed", changed, 1);

    // settle both low
    sw_a_raw = 1'b0; sw_b_raw = 1'b0;
    steps(10);

    // 2. Clean step on A
    sw_a_raw = 1'b1;
    steps(6);
    chk("step_a_early", a, 0);
    step();
    chk("step_a", a, 1);
    chk("step_changed", changed, 1);
    chk("step_b", b, 0);
    step();
    chk("step_changed_once", changed, 0);

    // 3. Bounce on B: 1,1,0,0,1,1,0,0 then hold 1
    for (int i = 0; i < 8; i++) begin
      sw_b_raw = ((i / 2) % 2 == 0);
      step();
      chk("bounce_b", b, 0);
    end
    sw_b_raw = 1'b1;
    steps(6);
    chk("bounce_b_early", b, 0);
    step();
    chk("bounce_b_set", b, 1);

    // 6 (edge pulses) + settle: A falls, B stays high
    sw_a_raw = 1'b0;
    steps(6);
    chk("fall_a_early", a, 1);
    step();
    chk("fall_a", a, 0);
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    chk("fall_a_fall", a_fall, 1);
    chk("fall_a_rise", a_rise, 0);
    chk("fall_b_rise", b_rise, 0);
    chk("fall_b_fall", b_fall, 0);
    step();
    chk("fall_a_fall_once", a_fall, 0);
`endif
    sw_b_raw = 1'b0;
    steps(10);

    // 4. Simultaneous rise
    sw_a_raw = 1'b1; sw_b_raw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += changed;
    end
    chk("sim_a_early", a, 0);
    chk("sim_b_early", b, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      pulses += changed;
    end
    chk("sim_a", a, 1);
    chk("sim_b", b, 1);
    chk("sim_pulses", pulses, 1);

    // 5. Short glitch: A low, then high for 3 sampled edges
    sw_a_raw = 1'b0;
    steps(10);
    sw_a_raw = 1'b1;
    steps(3);
    sw_a_raw = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      pulses += changed;
      chk("glitch_a", a, 0);
    end
    chk("glitch_pulses", pulses, 0);

    // Table-driven vectors from both low
    sw_b_raw = 1'b0;
    steps(10);
    vecs.push_back('{ra: 1, rb: 0, hold: 8, ea: 1, eb: 0});
    vecs.push_back('{ra: 1, rb: 1, hold: 8, ea: 1, eb: 1});
    vecs.push_back('{ra: 0, rb: 1, hold: 8, ea: 0, eb: 1});
    vecs.push_back('{ra: 0, rb: 0, hold: 8, ea: 0, eb: 0});
    vecs.push_back('{ra: 1, rb: 1, hold: 3, ea: 0, eb: 0});
    vecs.push_back('{ra: 0, rb: 0, hold: 8, ea: 0, eb: 0});
    vecs.push_back('{ra: 0, rb: 1, hold: 6, ea: 0, eb: 0});
    vecs.push_back('{ra: 0, rb: 1, hold: 1, ea: 0, eb: 1});
    vecs.push_back('{ra: 1, rb: 0, hold: 7, ea: 1, eb: 0});
    foreach (vecs[i]) begin
      sw_a_raw = vecs[i].ra;
      sw_b_raw = vecs[i].rb;
      steps(vecs[i].hold);
      chk($sformatf("vec%0d_a", i), a, vecs[i].ea);
      chk($sformatf("vec%0d_b", i), b, vecs[i].eb);
    end

    // Random bouncy stimulus
    for (int i = 0; i < 250; i++) begin
      sw_a_raw = 1'($urandom_range(0, 1));
      sw_b_raw = 1'($urandom_range(0, 1));
      steps($urandom_range(1, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
